// File: rtl/dmem_lane_bridge_if.sv
// Bus bundle between a core load/store port, the lane bridge and a byte-laned data memory.
// The bridge uses the slave modport; the core/memory environment uses master.
interface dmem_lane_bridge_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 8
);
  localparam int DW   = LANES * LANE_W;
  localparam int WA_W = ADDR_W - $clog2(LANES);

  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DW-1:0]     req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              suspend;
  logic [LANES-1:0]  ce_mem;
  logic [LANES-1:0]  we_mem;
  logic [WA_W-1:0]   mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, suspend,
           ce_mem, we_mem, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, suspend,
           ce_mem, we_mem, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_lane_bridge.sv
// Core load/store to byte-laned memory bridge: lane enables, store positioning, load extraction/extension.
// Define DMEM_BRIDGE_ERR_EN to reject misaligned accesses with rsp_err instead of forcing alignment.
module dmem_lane_bridge #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  dmem_lane_bridge_if.slave bus
);
  localparam int DW    = LANES * LANE_W;
  localparam int OFF_W = $clog2(LANES);
  localparam int WA_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t state, next_state;

  logic [OFF_W-1:0] req_off;
  logic [OFF_W-1:0] acc_off;
  logic [OFF_W:0]   acc_n;
  logic [LANES-1:0] acc_mask;
  logic [DW-1:0]    acc_wdata;
  logic             req_err;

  logic             lat_write;
  logic             lat_unsigned;
  logic [OFF_W-1:0] lane_off;
  logic [OFF_W:0]   lane_n;
  logic [LANES-1:0] lane_mask;
  logic [2:0]       wait_cnt;
  logic [WA_W-1:0]  mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;
  logic [DW-1:0]    rsp_rdata_q;
  logic             rsp_err_q;

  logic [DW-1:0]    shifted;
  logic [DW-1:0]    keep_mask;
  logic             sign_bit;
  logic [DW-1:0]    load_data;

  // Oversized accesses clamp to a full word; the offset is rounded down to the access size.
  always_comb begin
    req_off = bus.req_addr[OFF_W-1:0];
    if (int'(bus.req_size) > OFF_W) begin
      acc_n = (OFF_W+1)'(LANES);
    end else begin
      acc_n = (OFF_W+1)'(1) << bus.req_size;
    end
    acc_off   = req_off & ~(acc_n[OFF_W-1:0] - OFF_W'(1));
    acc_mask  = LANES'(((32'd1 << acc_n) - 32'd1) << acc_off);
    acc_wdata = (bus.req_wdata & ((DW'(1) << (int'(acc_n) * LANE_W)) - DW'(1)))
                << (int'(acc_off) * LANE_W);
  end

`ifdef DMEM_BRIDGE_ERR_EN
  assign req_err = (int'(bus.req_size) > OFF_W) ||
                   ((req_off & (acc_n[OFF_W-1:0] - OFF_W'(1))) != '0);
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    shifted   = bus.mem_rdata >> (int'(lane_off) * LANE_W);
    keep_mask = (DW'(1) << (int'(lane_n) * LANE_W)) - DW'(1);
    sign_bit  = |(shifted & (DW'(1) << (int'(lane_n) * LANE_W - 1)));
    load_data = (shifted & keep_mask) |
                ((lat_unsigned || !sign_bit) ? '0 : ~keep_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.suspend   = 1'b0;
    bus.ce_mem    = '0;
    bus.we_mem    = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.suspend = 1'b1;
        bus.ce_mem  = lane_mask;
        bus.we_mem  = lat_write ? lane_mask : '0;
        next_state  = lat_write ? RESP : WAIT;
      end
      WAIT: begin
        bus.suspend = 1'b1;
        if (wait_cnt == 3'd0) next_state = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The response registers change only on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lane_off     <= '0;
      lane_n       <= '0;
      lane_mask    <= '0;
      wait_cnt     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write    <= bus.req_write;
            lat_unsigned <= bus.req_unsigned;
            lane_off     <= acc_off;
            lane_n       <= acc_n;
            lane_mask    <= acc_mask;
            wait_cnt     <= 3'(RD_LAT - 1);
            mem_addr_q   <= bus.req_addr[ADDR_W-1:OFF_W];
            mem_wdata_q  <= acc_wdata;
            if (req_err) begin
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (lat_write) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            rsp_rdata_q <= load_data;
            rsp_err_q   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lane_bridge.sv
// Bench for dmem_lane_bridge: directed vector table, randomized traffic against a lane-level
// memory model, and a reset-abort sequence on a second instance with RD_LAT=3.
module tb_dmem_lane_bridge;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int ADDR_W = 8;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_lane_bridge_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus ();
  dmem_lane_bridge_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus2 ();

  dmem_lane_bridge #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  dmem_lane_bridge #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .RD_LAT(3)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  // Memory behind the main instance; idle cycles return a poison pattern so mistimed sampling shows.
  logic [31:0] phys_mem [64];
  logic [31:0] ref_mem  [64];
  logic [31:0] rd_q;
  logic [31:0] p2 [3];

  always @(posedge clk) begin
    if (bus.ce_mem != 4'b0) begin
      for (int k = 0; k < 4; k++)
        if (bus.we_mem[k]) phys_mem[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
      rd_q <= phys_mem[bus.mem_addr];
    end else begin
      rd_q <= 32'hA5A5A5A5;
    end
  end
  assign bus.mem_rdata = rd_q;

  always @(posedge clk) begin
    p2[0] <= (bus2.ce_mem != 4'b0) ? 32'h87654321 : 32'hA5A5A5A5;
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign bus2.mem_rdata = p2[2];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] size, input logic uns,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [3:0] mask, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic err, input int lat);
    vec_t v;
    v.write = w; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_mask = mask; v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  // Reference model: works on whole lanes of a word array and updates it for stores.
  function automatic vec_t refModel(input logic w, input logic [1:0] size, input logic uns,
                                    input logic [7:0] addr, input logic [31:0] wdata);
    vec_t v;
    int n;
    int off;
    int word;
    longint unsigned lanebits;
    longint unsigned val;
    v = mk(w, size, uns, addr, wdata, 4'h0, 32'h0, 32'h0, 1'b0, 0);
    n    = 1 << size;
    off  = int'(addr) % 4;
    word = int'(addr) / 4;
`ifdef DMEM_BRIDGE_ERR_EN
    if (n > 4 || (off % n) != 0) begin
      v.exp_err = 1'b1;
      v.exp_lat = 1;
      return v;
    end
`endif
    if (n > 4) n = 4;
    off = off - (off % n);
    v.exp_mask = 4'(((1 << n) - 1) << off);
    lanebits   = (64'd1 << (8 * n)) - 64'd1;
    if (w) begin
      v.exp_wdata   = 32'((64'(wdata) & lanebits) << (8 * off));
      ref_mem[word] = (ref_mem[word] & ~32'(lanebits << (8 * off))) | v.exp_wdata;
      v.exp_lat     = 2;
    end else begin
      val = (64'(ref_mem[word]) >> (8 * off)) & lanebits;
      if (!uns && ((val >> (8 * n - 1)) & 64'd1) == 64'd1) val = val | ~lanebits;
      v.exp_rdata = 32'(val);
      v.exp_lat   = 3;
    end
    return v;
  endfunction

  // Entered at a negedge with the bridge idle; returns at the negedge of the cycle after RESP.
  task automatic applyStimulus(input vec_t v, input bit junk);
    int          lat;
    int          ce_cycles;
    logic [3:0]  ce_seen;
    logic [3:0]  we_seen;
    logic [31:0] wd_seen;
    logic [5:0]  addr_seen;
    logic [31:0] rdata_at;
    logic        err_at;
    bit          susp_ok;
    bit          ready_ok;
    lat = 0; ce_cycles = 0; ce_seen = '0; we_seen = '0; wd_seen = '0; addr_seen = '0;
    rdata_at = '0; err_at = 1'b0; susp_ok = 1'b1; ready_ok = 1'b1;
    checkOutput("ready_idle", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_write    = v.write;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.req_ready) ready_ok = 1'b0;
      if (bus.ce_mem != 4'b0) begin
        ce_cycles++;
        ce_seen = bus.ce_mem; we_seen = bus.we_mem;
        wd_seen = bus.mem_wdata; addr_seen = bus.mem_addr;
      end
      if (bus.rsp_valid) begin
        if (bus.suspend) susp_ok = 1'b0;
        lat = c; rdata_at = bus.rsp_rdata; err_at = bus.rsp_err;
        bus.req_valid = 1'b0;
        break;
      end
      if (!bus.suspend) susp_ok = 1'b0;
      if (c == 1) begin
        bus.req_valid = junk;
        if (junk) begin
          bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
          bus.req_addr  = 8'($urandom); bus.req_wdata = $urandom;
        end
      end
    end
    bus.req_valid = 1'b0;
    checkOutput("rsp_latency", lat, v.exp_lat);
    checkOutput("rsp_err", err_at, v.exp_err);
    checkOutput("rsp_rdata", rdata_at, v.exp_rdata);
    checkOutput("ce_cycles", ce_cycles, v.exp_err ? 0 : 1);
    checkOutput("ce_mem", ce_seen, v.exp_mask);
    checkOutput("we_mem", we_seen, v.write ? v.exp_mask : 4'h0);
    if (!v.exp_err) checkOutput("mem_addr", addr_seen, v.addr[7:2]);
    if (v.write && !v.exp_err) checkOutput("mem_wdata", wd_seen, v.exp_wdata);
    checkOutput("suspend", susp_ok, 1);
    checkOutput("ready_busy", ready_ok, 1);
    @(negedge clk);
    checkOutput("rdata_hold", bus.rsp_rdata, v.exp_rdata);
    checkOutput("rsp_pulse", bus.rsp_valid, 0);
  endtask

  vec_t tbl [16];
  vec_t rv;
  int   lat2;
  bit   seen;
  logic [31:0] rd2;

  initial begin
    tbl[0]  = mk(1, 2, 0, 8'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 0, 2);
    tbl[1]  = mk(1, 0, 0, 8'h13, 32'h00000080, 4'h8, 32'h80000000, 32'h0, 0, 2);
    tbl[2]  = mk(0, 0, 0, 8'h13, 32'h0, 4'h8, 32'h0, 32'hFFFFFF80, 0, 3);
    tbl[3]  = mk(1, 1, 0, 8'h06, 32'h00001234, 4'hC, 32'h12340000, 32'h0, 0, 2);
    tbl[4]  = mk(0, 1, 1, 8'h06, 32'h0, 4'hC, 32'h0, 32'h00001234, 0, 3);
    tbl[5]  = mk(0, 2, 0, 8'h10, 32'h0, 4'hF, 32'h0, 32'h80ADBEEF, 0, 3);
    tbl[6]  = mk(0, 1, 0, 8'h12, 32'h0, 4'hC, 32'h0, 32'hFFFF80AD, 0, 3);
    tbl[7]  = mk(0, 0, 1, 8'h11, 32'h0, 4'h2, 32'h0, 32'h000000BE, 0, 3);
    tbl[8]  = mk(0, 0, 0, 8'h11, 32'h0, 4'h2, 32'h0, 32'hFFFFFFBE, 0, 3);
    tbl[9]  = mk(1, 2, 0, 8'h00, 32'h11223344, 4'hF, 32'h11223344, 32'h0, 0, 2);
    tbl[10] = mk(1, 1, 0, 8'h04, 32'hFFFF5678, 4'h3, 32'h00005678, 32'h0, 0, 2);
    tbl[11] = mk(0, 2, 1, 8'h04, 32'h0, 4'hF, 32'h0, 32'h12345678, 0, 3);
`ifdef DMEM_BRIDGE_ERR_EN
    tbl[12] = mk(0, 2, 0, 8'h02, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    tbl[13] = mk(1, 3, 0, 8'h21, 32'hCAFEF00D, 4'h0, 32'h0, 32'h0, 1, 1);
    tbl[14] = mk(0, 3, 1, 8'h21, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    tbl[15] = mk(0, 1, 0, 8'h07, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
`else
    tbl[12] = mk(0, 2, 0, 8'h02, 32'h0, 4'hF, 32'h0, 32'h11223344, 0, 3);
    tbl[13] = mk(1, 3, 0, 8'h21, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0, 0, 2);
    tbl[14] = mk(0, 3, 1, 8'h21, 32'h0, 4'hF, 32'h0, 32'hCAFEF00D, 0, 3);
    tbl[15] = mk(0, 1, 0, 8'h07, 32'h0, 4'hC, 32'h0, 32'h00001234, 0, 3);
`endif

    for (int i = 0; i < 64; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    reset = 1'b1; reset2 = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_size = 2'd0;
    bus2.req_unsigned = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_ready", bus.req_ready, 1);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rdata", bus.rsp_rdata, 0);
    checkOutput("rst_err", bus.rsp_err, 0);
    checkOutput("rst_suspend", bus.suspend, 0);
    checkOutput("rst_ce_we", {bus.ce_mem, bus.we_mem}, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) begin
      rv = refModel(tbl[i].write, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata);
      applyStimulus(tbl[i], 1'b0);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      rv = refModel(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 31)), $urandom);
      applyStimulus(rv, 1'b1);
    end

    $display("[TB] reset during WAIT with RD_LAT=3");
    reset2 = 1'b0;
    bus2.req_valid = 1'b1; bus2.req_write = 1'b0; bus2.req_size = 2'd2;
    bus2.req_unsigned = 1'b0; bus2.req_addr = 8'h04;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    checkOutput("d2_suspend_access", bus2.suspend, 1);
    @(negedge clk);
    checkOutput("d2_suspend_wait", bus2.suspend, 1);
    @(negedge clk);
    reset2 = 1'b1;
    bus2.req_valid = 1'b1;
    @(negedge clk);
    checkOutput("d2_ready_after_rst", bus2.req_ready, 1);
    checkOutput("d2_ce_after_rst", bus2.ce_mem, 0);
    checkOutput("d2_rsp_after_rst", bus2.rsp_valid, 0);
    checkOutput("d2_suspend_after_rst", bus2.suspend, 0);
    checkOutput("d2_rdata_after_rst", bus2.rsp_rdata, 0);
    reset2 = 1'b0;
    bus2.req_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus2.rsp_valid || bus2.suspend) seen = 1'b1;
    end
    checkOutput("d2_aborted_quiet", seen, 0);

    bus2.req_valid = 1'b1; bus2.req_size = 2'd0; bus2.req_unsigned = 1'b0; bus2.req_addr = 8'h03;
    lat2 = 0; rd2 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus2.req_valid = 1'b0;
      if (bus2.rsp_valid) begin
        lat2 = c; rd2 = bus2.rsp_rdata;
        break;
      end
    end
    bus2.req_valid = 1'b0;
    checkOutput("d2_load_latency", lat2, 5);
    checkOutput("d2_load_rdata", rd2, 32'hFFFFFF87);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
